// File: rtl/uncache_axi_slave_if.sv
// AXI4 bus bundle between the dcache uncache master and its slave.
// Ports: AR/R/AW/W/B channel signals; master and slave modports.
interface uncache_axi_slave_if #(
  parameter int ID_W = 4
);
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic            arvalid;
  logic            arready;

  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic            awvalid;
  logic            awready;

  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;

  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  modport master (
    output arid, araddr, arlen, arsize, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/uncache_axi_slave.sv
// Uncached peripheral window: 14 scratch regs, timer (14), led/switch (15).
// Ports: clk, resetn, axi (slave modport), switch in, led out.
module uncache_axi_slave #(
  parameter logic [31:0] BASE_ADDR  = 32'h1FAF_0000,
  parameter int          RD_LATENCY = 1,
  parameter int          ID_W       = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  uncache_axi_slave_if.slave   axi,
  input  logic [15:0]          switch,
  output logic [15:0]          led
);

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_DATA
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_t;

  function automatic logic [31:0] merge(
    input logic [31:0] o,
    input logic [31:0] n,
    input logic [3:0]  s
  );
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = s[b] ? n[8*b +: 8] : o[8*b +: 8];
    end
    return r;
  endfunction

  logic [31:0] regs [14];
  logic [31:0] timer;

  r_state_t        r_state;
  logic [3:0]      r_cnt;
  logic [7:0]      r_len;
  logic [7:0]      r_beat;
  logic [3:0]      r_idx;
  logic            r_err;
  logic [ID_W-1:0] r_id;
  logic [31:0]     rd_val;

  w_state_t        w_state;
  logic [3:0]      w_idx;
  logic            w_err;
  logic            w_first;
  logic [ID_W-1:0] w_id;
  logic            wr_en;

  logic unused_bits;
  assign unused_bits = ^{axi.araddr[15:6], axi.araddr[1:0],
                         axi.awaddr[15:6], axi.awaddr[1:0],
                         axi.arsize, axi.awsize};

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      r_idx == 4'd14: rd_val = timer;
      r_idx == 4'd15: rd_val = {16'h0, switch};
      default:        rd_val = regs[r_idx];
    endcase
  end

  // Read FSM: data is sampled as R_WAIT exits, then held for every beat.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= R_IDLE;
      axi.arready <= 1'b1;
      axi.rvalid  <= 1'b0;
      axi.rlast   <= 1'b0;
      axi.rdata   <= '0;
      axi.rid     <= '0;
      axi.rresp   <= OKAY;
      r_cnt       <= '0;
      r_len       <= '0;
      r_beat      <= '0;
      r_idx       <= '0;
      r_err       <= 1'b0;
      r_id        <= '0;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          if (axi.arvalid) begin
            axi.arready <= 1'b0;
            r_id        <= axi.arid;
            r_idx       <= axi.araddr[5:2];
            r_len       <= axi.arlen;
            r_err       <= (axi.araddr[31:16] != BASE_ADDR[31:16])
                           || (axi.arlen != 8'd0);
            r_cnt       <= 4'(RD_LATENCY - 1);
            r_state     <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (r_cnt == 4'd0) begin
            axi.rvalid <= 1'b1;
            axi.rdata  <= r_err ? 32'h0 : rd_val;
            axi.rresp  <= r_err ? SLVERR : OKAY;
            axi.rid    <= r_id;
            axi.rlast  <= (r_len == 8'd0);
            r_beat     <= '0;
            r_state    <= R_DATA;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        R_DATA: begin
          if (axi.rready) begin
            if (axi.rlast) begin
              axi.rvalid  <= 1'b0;
              axi.rlast   <= 1'b0;
              axi.arready <= 1'b1;
              r_state     <= R_IDLE;
            end else begin
              r_beat    <= r_beat + 8'd1;
              axi.rlast <= (r_beat + 8'd1 == r_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Write FSM: only the first beat of an error-free burst commits.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state     <= W_IDLE;
      axi.awready <= 1'b1;
      axi.wready  <= 1'b0;
      axi.bvalid  <= 1'b0;
      axi.bid     <= '0;
      axi.bresp   <= OKAY;
      w_idx       <= '0;
      w_err       <= 1'b0;
      w_first     <= 1'b0;
      w_id        <= '0;
    end else begin
      unique case (w_state)
        W_IDLE: begin
          if (axi.awvalid) begin
            axi.awready <= 1'b0;
            axi.wready  <= 1'b1;
            w_id        <= axi.awid;
            w_idx       <= axi.awaddr[5:2];
            w_err       <= (axi.awaddr[31:16] != BASE_ADDR[31:16])
                           || (axi.awlen != 8'd0);
            w_first     <= 1'b1;
            w_state     <= W_DATA;
          end
        end
        W_DATA: begin
          if (axi.wvalid) begin
            w_first <= 1'b0;
            if (axi.wlast) begin
              axi.wready <= 1'b0;
              axi.bvalid <= 1'b1;
              axi.bid    <= w_id;
              axi.bresp  <= w_err ? SLVERR : OKAY;
              w_state    <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (axi.bready) begin
            axi.bvalid  <= 1'b0;
            axi.awready <= 1'b1;
            w_state     <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  assign wr_en = (w_state == W_DATA) && axi.wvalid
                 && w_first && !w_err;

  // A timer write overrides that cycle's increment.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 14; i++) begin
        regs[i] <= '0;
      end
      timer <= '0;
      led   <= '0;
    end else begin
      timer <= timer + 32'd1;
      if (wr_en) begin
        unique case (1'b1)
          w_idx == 4'd14: begin
            timer <= merge(timer, axi.wdata, axi.wstrb);
          end
          w_idx == 4'd15: begin
            if (axi.wstrb[0]) led[7:0]  <= axi.wdata[7:0];
            if (axi.wstrb[1]) led[15:8] <= axi.wdata[15:8];
          end
          default: begin
            regs[w_idx] <= merge(regs[w_idx], axi.wdata, axi.wstrb);
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uncache_axi_slave.sv
// Scoreboard bench for uncache_axi_slave.
// Stimulus pushes expected R/B responses; a negedge monitor checks them.
module tb_uncache_axi_slave;

  localparam int BOUND = 100;
  localparam logic [31:0] B = 32'h1FAF_0000;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } r_exp_t;

  typedef struct {
    logic [1:0] resp;
    logic [3:0] id;
  } b_exp_t;

  logic        clk;
  logic        resetn;
  logic [15:0] sw;
  logic [15:0] led;

  int ncmp;
  int nerr;
  int cyc;
  int aw_cyc;
  int w_cyc;
  int ar_cyc;
  int lat;
  int blat;

  r_exp_t r_q[$];
  b_exp_t b_q[$];

  uncache_axi_slave_if #(.ID_W(4)) axi ();

  uncache_axi_slave #(
    .BASE_ADDR(32'h1FAF_0000),
    .RD_LATENCY(1),
    .ID_W(4)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .axi(axi),
    .switch(sw),
    .led(led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic tmo(input string n);
    ncmp++;
    nerr++;
    $display("FAIL %s: timeout after %0d cycles", n, BOUND);
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      if (axi.rvalid && axi.rready) begin
        if (r_q.size() == 0) begin
          ncmp++;
          nerr++;
          $display("FAIL r_unexpected: got beat %h expected none",
                   axi.rdata);
        end else begin
          r_exp_t e;
          e = r_q.pop_front();
          chk("rdata", axi.rdata, e.data);
          chk("rresp", 32'(axi.rresp), 32'(e.resp));
          chk("rlast", 32'(axi.rlast), 32'(e.last));
          chk("rid", 32'(axi.rid), 32'(e.id));
        end
      end
      if (axi.bvalid && axi.bready) begin
        if (b_q.size() == 0) begin
          ncmp++;
          nerr++;
          $display("FAIL b_unexpected: got resp %b expected none",
                   axi.bresp);
        end else begin
          b_exp_t e;
          e = b_q.pop_front();
          chk("bresp", 32'(axi.bresp), 32'(e.resp));
          chk("bid", 32'(axi.bid), 32'(e.id));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // tmr=1: expected data is a timer value loaded to d at edge w_cyc.
  task automatic axi_read(input logic [31:0] a, input logic [7:0] len,
                          input logic [3:0] id, input logic [31:0] d,
                          input logic [1:0] resp, input int hold,
                          input bit tmr, output int l);
    int t;
    logic [31:0] ed;
    r_exp_t e;
    l = -1;
    axi.arid = id;
    axi.araddr = a;
    axi.arlen = len;
    axi.arvalid = 1'b1;
    if (hold > 0) axi.rready = 1'b0;
    t = 0;
    while (!axi.arready && t < BOUND) begin tick(); t++; end
    if (t >= BOUND) tmo("ar_wait");
    tick();
    axi.arvalid = 1'b0;
    ar_cyc = cyc;
    ed = tmr ? d + 32'(ar_cyc - w_cyc) : d;
    for (int i = 0; i <= int'(len); i++) begin
      e.data = ed;
      e.resp = resp;
      e.last = (i == int'(len));
      e.id = id;
      r_q.push_back(e);
    end
    t = 0;
    while (!axi.rvalid && t < BOUND) begin tick(); t++; end
    if (t >= BOUND) tmo("rvalid_wait");
    l = cyc - ar_cyc;
    for (int i = 0; i < hold; i++) begin
      if (i > 0) tick();
      chk("rvalid_hold", 32'(axi.rvalid), 32'd1);
      chk("rdata_hold", axi.rdata, ed);
    end
    axi.rready = 1'b1;
    t = 0;
    while (r_q.size() != 0 && t < BOUND) begin tick(); t++; end
    if (t >= BOUND) tmo("r_drain");
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [7:0] len,
                           input logic [3:0] id, input logic [31:0] d,
                           input logic [3:0] s, input logic [1:0] resp,
                           input int hold, output int l);
    int t;
    b_exp_t e;
    l = -1;
    e.resp = resp;
    e.id = id;
    b_q.push_back(e);
    axi.awid = id;
    axi.awaddr = a;
    axi.awlen = len;
    axi.awvalid = 1'b1;
    if (hold > 0) axi.bready = 1'b0;
    t = 0;
    while (!axi.awready && t < BOUND) begin tick(); t++; end
    if (t >= BOUND) tmo("aw_wait");
    tick();
    axi.awvalid = 1'b0;
    aw_cyc = cyc;
    for (int i = 0; i <= int'(len); i++) begin
      axi.wdata = d;
      axi.wstrb = s;
      axi.wlast = (i == int'(len));
      axi.wvalid = 1'b1;
      t = 0;
      while (!axi.wready && t < BOUND) begin tick(); t++; end
      if (t >= BOUND) tmo("wready_wait");
      tick();
    end
    w_cyc = cyc;
    axi.wvalid = 1'b0;
    axi.wlast = 1'b0;
    t = 0;
    while (!axi.bvalid && t < BOUND) begin tick(); t++; end
    if (t >= BOUND) tmo("bvalid_wait");
    l = cyc - aw_cyc;
    for (int i = 0; i < hold; i++) begin
      if (i > 0) tick();
      chk("bvalid_hold", 32'(axi.bvalid), 32'd1);
    end
    axi.bready = 1'b1;
    t = 0;
    while (b_q.size() != 0 && t < BOUND) begin tick(); t++; end
    if (t >= BOUND) tmo("b_drain");
  endtask

  initial begin
    int t;
    ncmp = 0;
    nerr = 0;
    cyc = 0;
    w_cyc = 0;
    resetn = 1'b0;
    sw = 16'h0;
    axi.arid = '0; axi.araddr = '0; axi.arlen = '0;
    axi.arsize = 3'd2; axi.arvalid = 1'b0; axi.rready = 1'b1;
    axi.awid = '0; axi.awaddr = '0; axi.awlen = '0;
    axi.awsize = 3'd2; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0;
    axi.wvalid = 1'b0; axi.bready = 1'b1;
    repeat (3) tick();
    chk("rst_arready", 32'(axi.arready), 32'd1);
    chk("rst_awready", 32'(axi.awready), 32'd1);
    chk("rst_rvalid", 32'(axi.rvalid), 32'd0);
    chk("rst_wready", 32'(axi.wready), 32'd0);
    chk("rst_bvalid", 32'(axi.bvalid), 32'd0);
    chk("rst_rdata", axi.rdata, 32'd0);
    chk("rst_led", 32'(led), 32'd0);
    resetn = 1'b1;
    tick();

    axi_write(B + 32'h08, 8'd0, 4'h1, 32'hDEADBEEF, 4'hF, 2'b00, 0, blat);
    chk("b_latency", 32'(blat), 32'd1);
    axi_read(B + 32'h08, 8'd0, 4'h2, 32'hDEADBEEF, 2'b00, 0, 0, lat);
    chk("r_latency", 32'(lat), 32'd1);

    axi_write(B + 32'h0C, 8'd0, 4'h3, 32'h11223344, 4'hF, 2'b00, 0, blat);
    axi_write(B + 32'h0C, 8'd0, 4'h3, 32'hAABBCCDD, 4'h5, 2'b00, 0, blat);
    axi_read(B + 32'h0C, 8'd0, 4'h4, 32'h11BB33DD, 2'b00, 0, 0, lat);

    axi_read(32'h1FB0_0000, 8'd0, 4'h5, 32'h0, 2'b10, 0, 0, lat);
    axi_read(B, 8'd3, 4'h6, 32'h0, 2'b10, 0, 0, lat);

    axi_write(B + 32'h14, 8'd0, 4'h8, 32'h00000055, 4'hF, 2'b00, 0, blat);
    axi_write(B + 32'h14, 8'd1, 4'h9, 32'hFFFFFFFF, 4'hF, 2'b10, 0, blat);
    axi_read(B + 32'h14, 8'd0, 4'hA, 32'h00000055, 2'b00, 0, 0, lat);

    axi_write(B + 32'h04, 8'd0, 4'h1, 32'h13579BDF, 4'hF, 2'b00, 0, blat);
    axi_read(B + 32'h04, 8'd0, 4'hB, 32'h13579BDF, 2'b00, 5, 0, lat);

    begin
      b_exp_t e;
      e.resp = 2'b00;
      e.id = 4'h7;
      b_q.push_back(e);
      axi.wdata = 32'h2468ACE0;
      axi.wstrb = 4'hF;
      axi.wlast = 1'b1;
      axi.wvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
        tick();
        chk("wready_early", 32'(axi.wready), 32'd0);
      end
      axi.awid = 4'h7;
      axi.awaddr = B + 32'h18;
      axi.awlen = 8'd0;
      axi.awvalid = 1'b1;
      chk("wready_aw_cycle", 32'(axi.wready), 32'd0);
      tick();
      axi.awvalid = 1'b0;
      chk("wready_after_aw", 32'(axi.wready), 32'd1);
      tick();
      axi.wvalid = 1'b0;
      axi.wlast = 1'b0;
      t = 0;
      while (b_q.size() != 0 && t < BOUND) begin tick(); t++; end
      if (t >= BOUND) tmo("b_early_drain");
    end
    axi_read(B + 32'h18, 8'd0, 4'hC, 32'h2468ACE0, 2'b00, 0, 0, lat);

    axi_write(B + 32'h10, 8'd0, 4'hD, 32'h0BADC0DE, 4'hF, 2'b00, 4, blat);
    axi_read(B + 32'h10, 8'd0, 4'hD, 32'h0BADC0DE, 2'b00, 0, 0, lat);

    fork
      axi_write(B + 32'h38, 8'd0, 4'h2, 32'hFFFFFFFE, 4'hF, 2'b00, 0,
                blat);
      begin
        tick();
        tick();
        axi_read(B + 32'h38, 8'd0, 4'h3, 32'hFFFFFFFE, 2'b00, 0, 1, lat);
      end
    join
    axi_read(B + 32'h38, 8'd0, 4'h4, 32'hFFFFFFFE, 2'b00, 0, 1, lat);

    axi_write(B + 32'h3C, 8'd0, 4'h5, 32'h0000A5A5, 4'hF, 2'b00, 0, blat);
    chk("led", 32'(led), 32'h0000A5A5);
    sw = 16'h1234;
    axi_read(B + 32'h3C, 8'd0, 4'h6, 32'h00001234, 2'b00, 0, 0, lat);

    axi_write(B, 8'd0, 4'h7, 32'hCAFEF00D, 4'hF, 2'b00, 0, blat);
    axi.rready = 1'b0;
    axi.arid = 4'h8;
    axi.araddr = B;
    axi.arlen = 8'd3;
    axi.arvalid = 1'b1;
    tick();
    axi.arvalid = 1'b0;
    t = 0;
    while (!axi.rvalid && t < BOUND) begin tick(); t++; end
    if (t >= BOUND) tmo("rst_burst_rvalid");
    tick();
    resetn = 1'b0;
    #1;
    chk("rst_mid_rvalid", 32'(axi.rvalid), 32'd0);
    tick();
    resetn = 1'b1;
    tick();
    chk("rst_mid_arready", 32'(axi.arready), 32'd1);
    chk("rst_mid_led", 32'(led), 32'd0);
    axi.rready = 1'b1;
    axi_read(B, 8'd0, 4'h9, 32'h0, 2'b00, 0, 0, lat);

    chk("r_q_empty", 32'(r_q.size()), 32'd0);
    chk("b_q_empty", 32'(b_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
